// File: rtl/bayer_pkg.sv
// bayer_pkg: shared widths, capture state encoding and pixel-bus type for the Bayer pipeline
package bayer_pkg;
    localparam int DATA_W  = 12;
    localparam int CNT_W   = 11;
    localparam int FRAME_W = 32;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} cap_state_t;

    typedef struct packed {
        logic              fval;
        logic              lval;
        logic [DATA_W-1:0] data;
    } pix_bus_t;
endpackage

// File: rtl/bayer_raw_capture_if.sv
// bayer_raw_capture_if: sensor-side inputs and capture outputs of the raw Bayer capture block
interface bayer_raw_capture_if;
    import bayer_pkg::*;
    logic [DATA_W-1:0]  iDATA;
    logic               iFVAL;
    logic               iLVAL;
    logic               iSTART;
    logic               iEND;
    logic [DATA_W-1:0]  oDATA;
    logic               oDVAL;
    logic [CNT_W-1:0]   oX_Cont;
    logic [CNT_W-1:0]   oY_Cont;
    logic [FRAME_W-1:0] oFrame_Cont;
    logic               oLineErr;

    modport master (
        output iDATA, iFVAL, iLVAL, iSTART, iEND,
        input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oLineErr
    );

    modport slave (
        input  iDATA, iFVAL, iLVAL, iSTART, iEND,
        output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oLineErr
    );
endinterface

// File: rtl/bayer_raw_capture.sv
// bayer_raw_capture: frame-gated capture of the raw sensor stream with column/row/frame counters
module bayer_raw_capture
    import bayer_pkg::*;
#(
    parameter int H_MAX = 1280
) (
    input logic                iCLK,
    input logic                iRST,
    bayer_raw_capture_if.slave bus
);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_MAX - 1);
    localparam logic [CNT_W-1:0] Y_SAT  = '1;

    cap_state_t         state_q, state_d;
    pix_bus_t           pix_d1_q, pix_d1_d;
    logic               prev_fval_q, lval_d2_q;
    logic               stop_q, stop_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               dval_q, dval_d;
    logic [CNT_W-1:0]   x_q, x_d, y_q, y_d, ox_q, ox_d, oy_q, oy_d, y_inc;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               err_q, err_d;
    logic               frame_start, frame_end, capturing, valid, start_cap, short_line, row_done;

    // state register; reset parks the block in IDLE until re-armed
    always_ff @(posedge iCLK) begin
        if (iRST) state_q <= IDLE;
        else state_q <= state_d;
    end

    // next state: arming only waits for a frame edge, so capture never starts mid-frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.iSTART && !bus.iEND) state_d = ARMED;
            ARMED:   state_d = bus.iEND ? IDLE : (frame_start ? CAPTURE : ARMED);
            CAPTURE: if (frame_end) state_d = (stop_q || bus.iEND) ? IDLE : ARMED;
            default: state_d = IDLE;
        endcase
    end

    // state-derived strobes built on the once-registered sensor signals
    always_comb begin
        frame_start = pix_d1_q.fval && !prev_fval_q;
        frame_end   = !pix_d1_q.fval && prev_fval_q;
        capturing   = state_q == CAPTURE;
        valid       = capturing && pix_d1_q.fval && pix_d1_q.lval;
        start_cap   = state_q == ARMED && !bus.iEND && frame_start;
        short_line  = capturing && lval_d2_q && !pix_d1_q.lval && x_q != '0;
        row_done    = short_line || (valid && x_q == X_LAST);
    end

    // datapath next values; x_q/y_q address the next pixel, ox/oy latch the one on oDATA
    always_comb begin
        pix_d1_d = '{fval: bus.iFVAL, lval: bus.iLVAL, data: bus.iDATA};
        y_inc    = (y_q == Y_SAT) ? y_q : y_q + 1'b1;
        stop_d   = capturing && !frame_end && (stop_q || bus.iEND);
        data_d   = valid ? pix_d1_q.data : data_q;
        dval_d   = valid;
        ox_d     = start_cap ? '0 : (valid ? x_q : ox_q);
        oy_d     = start_cap ? '0 : (valid ? y_q : oy_q);
        x_d      = (start_cap || row_done) ? '0 : (valid ? x_q + 1'b1 : x_q);
        y_d      = start_cap ? '0 : (row_done ? y_inc : y_q);
        err_d    = !start_cap && (err_q || short_line);
        frame_d  = (capturing && frame_end) ? frame_q + 1'b1 : frame_q;
    end

    // datapath registers; fval history resets high so reset never fakes a frame edge
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pix_d1_q    <= '{fval: 1'b1, lval: 1'b0, data: '0};
            prev_fval_q <= 1'b1;
            lval_d2_q   <= 1'b0;
            stop_q      <= 1'b0;
            data_q      <= '0;
            dval_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            frame_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            pix_d1_q    <= pix_d1_d;
            prev_fval_q <= pix_d1_q.fval;
            lval_d2_q   <= pix_d1_q.lval;
            stop_q      <= stop_d;
            data_q      <= data_d;
            dval_q      <= dval_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
        end
    end

    assign bus.oDATA       = data_q;
    assign bus.oDVAL       = dval_q;
    assign bus.oX_Cont     = ox_q;
    assign bus.oY_Cont     = oy_q;
    assign bus.oFrame_Cont = frame_q;
    assign bus.oLineErr    = err_q;
endmodule

// File: tb/tb_bayer_raw_capture.sv
// tb_bayer_raw_capture: directed and randomized capture scenarios against a behavioural model
module tb_bayer_raw_capture;
    import bayer_pkg::*;
    localparam int HM = 4;
    localparam int YS = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bayer_raw_capture_if bus();
    bayer_raw_capture #(.H_MAX(HM)) dut (.iCLK(clk), .iRST(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit st_v = 0, en_v = 0;
    int dn = 0;

    int m_mode;
    bit m_f1, m_l1, m_pf, m_l2, m_stop;
    int m_d1, m_x, m_y;
    int e_data, e_x, e_y, e_frame;
    bit e_dval, e_err;

    typedef struct {int d; int x; int y;} pix_t;
    pix_t log_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_f1 = 1; m_pf = 1; m_l1 = 0; m_l2 = 0; m_stop = 0;
        m_d1 = 0; m_x = 0; m_y = 0;
        e_data = 0; e_x = 0; e_y = 0; e_frame = 0; e_dval = 0; e_err = 0;
    endtask

    task automatic model_edge(input bit f, input bit l, input int d, input bit st, input bit en);
        bit fs = m_f1 && !m_pf;
        bit fe = !m_f1 && m_pf;
        bit take = m_mode == 2 && m_f1 && m_l1;
        e_dval = take;
        if (take) begin
            e_data = m_d1; e_x = m_x; e_y = m_y;
            m_x++;
            if (m_x == HM) begin
                m_x = 0;
                m_y = (m_y == YS) ? YS : m_y + 1;
            end
        end else if (m_mode == 2 && m_l2 && !m_l1 && m_x != 0) begin
            m_x = 0;
            m_y = (m_y == YS) ? YS : m_y + 1;
            e_err = 1;
        end
        if (m_mode == 0) begin
            if (st && !en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (en) m_mode = 0;
            else if (fs) begin
                m_mode = 2; m_x = 0; m_y = 0; e_x = 0; e_y = 0; e_err = 0; m_stop = 0;
            end
        end else begin
            if (fe) begin
                e_frame++;
                m_mode = (m_stop || en) ? 0 : 1;
                m_stop = 0;
            end else if (en) m_stop = 1;
        end
        m_l2 = m_l1; m_pf = m_f1;
        m_f1 = f; m_l1 = l; m_d1 = d;
    endtask

    task automatic cyc(input bit f, input bit l, input int d);
        bus.iFVAL = f; bus.iLVAL = l; bus.iDATA = DATA_W'(d);
        bus.iSTART = st_v; bus.iEND = en_v;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(f, l, d, st_v, en_v);
        #1;
        chk("oDVAL", bus.oDVAL, e_dval);
        chk("oDATA", bus.oDATA, e_data);
        chk("oX_Cont", bus.oX_Cont, e_x);
        chk("oY_Cont", bus.oY_Cont, e_y);
        chk("oFrame_Cont", bus.oFrame_Cont, e_frame);
        chk("oLineErr", bus.oLineErr, e_err);
        if (bus.oDVAL) log_q.push_back('{int'(bus.oDATA), int'(bus.oX_Cont), int'(bus.oY_Cont)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic line(input int n, input bit seq);
        for (int i = 0; i < n; i++) begin
            if (seq) dn++;
            cyc(1, 1, seq ? dn : int'($urandom_range(0, 4095)));
        end
        cyc(1, 0, 0);
    endtask

    task automatic frame(input int lines, input int n, input bit seq);
        cyc(1, 0, 0);
        for (int i = 0; i < lines; i++) line(n, seq);
        idle(2);
    endtask

    initial begin
        bus.iFVAL = 0; bus.iLVAL = 0; bus.iDATA = '0; bus.iSTART = 0; bus.iEND = 0;
        rst = 1;
        cyc(0, 0, 0);
        chk("reset_state", dut.state_q, IDLE);
        chk("reset_dval", bus.oDVAL, 1'b0);
        rst = 0;

        st_v = 1; idle(2); st_v = 0;
        log_q.delete(); dn = 0;
        frame(2, 4, 1);
        chk("f1_count", log_q.size(), 8);
        for (int k = 0; k < 8 && k < log_q.size(); k++) begin
            chk("f1_data", log_q[k].d, k + 1);
            chk("f1_x", log_q[k].x, k % 4);
            chk("f1_y", log_q[k].y, k / 4);
        end
        chk("f1_frames", bus.oFrame_Cont, 1);
        chk("f1_state", dut.state_q, ARMED);

        en_v = 1; idle(1); en_v = 0; idle(1);
        log_q.delete();
        cyc(1, 0, 0); line(4, 0);
        st_v = 1; line(4, 0); st_v = 0;
        idle(2);
        chk("mid_start_nodval", log_q.size(), 0);
        cyc(1, 0, 0); line(4, 0);
        en_v = 1; line(4, 0); idle(2); en_v = 0;
        chk("f2_count", log_q.size(), 8);
        if (log_q.size() > 0) begin
            chk("f2_first_x", log_q[0].x, 0);
            chk("f2_first_y", log_q[0].y, 0);
        end
        chk("f2_frames", bus.oFrame_Cont, 2);
        chk("f2_state", dut.state_q, IDLE);
        log_q.delete();
        frame(2, 4, 0);
        chk("f3_nodval", log_q.size(), 0);
        chk("f3_frames", bus.oFrame_Cont, 2);

        st_v = 1; idle(1); st_v = 0;
        log_q.delete();
        cyc(1, 0, 0); line(3, 0); cyc(1, 0, 0);
        chk("short_err", bus.oLineErr, 1'b1);
        line(4, 0); idle(2);
        chk("short_count", log_q.size(), 7);
        if (log_q.size() > 3) begin
            chk("short_next_x", log_q[3].x, 0);
            chk("short_next_y", log_q[3].y, 1);
        end
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        chk("err_cleared", bus.oLineErr, 1'b0);
        line(4, 0); idle(2);

        for (int f = 0; f < 8; f++) begin
            int nl = $urandom_range(1, 3);
            cyc(1, 0, 0);
            for (int l = 0; l < nl; l++) begin
                st_v = ($urandom_range(0, 3) == 0);
                en_v = ($urandom_range(0, 5) == 0);
                for (int p = $urandom_range(1, 6); p > 0; p--) cyc(1, 1, $urandom_range(0, 4095));
                for (int g = $urandom_range(1, 3); g > 0; g--) cyc(1, 0, 0);
            end
            for (int g = $urandom_range(1, 3); g > 0; g--) cyc(0, 0, 0);
        end
        st_v = 0; en_v = 0; idle(3);

        rst = 1; cyc(0, 0, 0); rst = 0;
        st_v = 1; idle(2); st_v = 0;
        cyc(1, 0, 0); cyc(1, 1, 11); cyc(1, 1, 12);
        rst = 1; cyc(1, 1, 13); rst = 0;
        chk("rst_mid_state", dut.state_q, IDLE);
        chk("rst_mid_dval", bus.oDVAL, 1'b0);
        chk("rst_mid_data", bus.oDATA, 0);
        chk("rst_mid_x", bus.oX_Cont, 0);
        chk("rst_mid_frames", bus.oFrame_Cont, 0);
        log_q.delete();
        st_v = 1; cyc(1, 1, 14); cyc(1, 1, 15); cyc(1, 0, 0); line(4, 0); st_v = 0;
        idle(2);
        chk("rst_mid_nodval", log_q.size(), 0);
        frame(1, 4, 0);
        chk("rst_recapture", log_q.size(), 4);

        en_v = 1; st_v = 1; idle(2);
        log_q.delete();
        frame(2, 4, 0); idle(2);
        en_v = 0; st_v = 0;
        chk("both_nodval", log_q.size(), 0);
        chk("both_state", dut.state_q, IDLE);

        st_v = 1; idle(1); st_v = 0;
        log_q.delete();
        cyc(1, 0, 0);
        for (int i = 0; i < YS + 5; i++) begin
            cyc(1, 1, $urandom_range(0, 4095));
            cyc(1, 0, 0);
        end
        idle(3);
        chk("sat_count", log_q.size(), YS + 5);
        if (log_q.size() > 0) chk("sat_y", log_q[log_q.size() - 1].y, YS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
